// File: rtl/return_coin_dispenser.sv
// Change-return stage: owns the inactivity timer and pays out the balance one
// coin per cycle, largest coin first, once a return is requested or the timer expires.
module return_coin_dispenser #(
  parameter int                      kNumCoins   = 3,
  parameter int                      kTotalBits  = 31,
  parameter int                      kWaitTime   = 10,
  parameter logic [kNumCoins*32-1:0] kCoinValues = {32'd1000, 32'd500, 32'd100}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic                  i_item_out,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] current_total,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic [31:0]           o_wait_time,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {IDLE, COUNT, DISPENSE, DONE} state_t;

  state_t                r_state,     w_state_nx;
  logic [kTotalBits-1:0] r_remaining, w_remaining_nx;
  logic [31:0]           r_wait,      w_wait_nx;
  logic [kNumCoins-1:0]  r_coin,      w_coin_nx;
  logic                  r_busy,      w_busy_nx;
  logic                  r_done,      w_done_nx;

  // Coin values resized to the money width so all compares/subtracts are same-width.
  logic [kTotalBits-1:0] w_coin_val [kNumCoins];
  for (genvar g = 0; g < kNumCoins; g++) begin : g_coin_val
    assign w_coin_val[g] = kTotalBits'(kCoinValues[g*32 +: 32]);
  end

  // Values ascend with index, so the last fitting coin in the scan is the largest.
  logic [kNumCoins-1:0]  w_sel;
  logic                  w_fit;
  logic [kTotalBits-1:0] w_sel_val;
  always_comb begin
    w_sel     = '0;
    w_fit     = 1'b0;
    w_sel_val = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (w_coin_val[i] <= r_remaining) begin
        w_sel     = '0;
        w_sel[i]  = 1'b1;
        w_fit     = 1'b1;
        w_sel_val = w_coin_val[i];
      end
    end
  end

  logic w_total_payable;
  assign w_total_payable = (current_total >= w_coin_val[0]);

  always_comb begin
    w_state_nx     = r_state;
    w_remaining_nx = r_remaining;
    w_wait_nx      = r_wait;
    w_coin_nx      = '0;
    w_busy_nx      = 1'b0;
    w_done_nx      = 1'b0;
    case (r_state)
      IDLE, COUNT: begin
        // Trigger beats a same-cycle coin: the snapshot excludes that coin.
        if (i_trigger_return) begin
          w_remaining_nx = current_total;
          w_wait_nx      = '0;
          w_state_nx     = w_total_payable ? DISPENSE : DONE;
        end else if ((|i_input_coin) || i_item_out) begin
          w_wait_nx  = 32'(kWaitTime);
          w_state_nx = COUNT;
        end else if (r_state == COUNT) begin
          if (r_wait > 32'd1) begin
            w_wait_nx = r_wait - 32'd1;
          end else begin
            w_wait_nx = '0;
            if ((r_wait == 32'd1) && w_total_payable) begin
              w_remaining_nx = current_total;
              w_state_nx     = DISPENSE;
            end else begin
              w_state_nx = IDLE;
            end
          end
        end
      end
      DISPENSE: begin
        if (w_fit) begin
          w_coin_nx      = w_sel;
          w_busy_nx      = 1'b1;
          w_remaining_nx = r_remaining - w_sel_val;
        end else begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        w_done_nx  = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_wait      <= '0;
      r_coin      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_remaining <= w_remaining_nx;
      r_wait      <= w_wait_nx;
      r_coin      <= w_coin_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
    end
  end

  assign o_return_coin = r_coin;
  assign o_wait_time   = r_wait;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
